// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, SR/Cause bit positions, ExcCode values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cp0_pkg;

  // mfc0/mtc0 register numbers
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  // SR / Cause field positions
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int IM_LSB   = 8;
  localparam int CAUSE_BD = 31;
  localparam int EXC_LSB  = 2;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match raises a sticky timer_irq.
// Latency: writes and the match flag take effect on the next clock edge.
// Backpressure: none; writes are always accepted.
module cp0_timer #(
  parameter int DATA_W   = 32,
  parameter int TIMER_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_count,
  input  logic              wr_compare,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              timer_irq
);

  logic [DATA_W-1:0] count_nxt;
  logic              fire;

  // next Count value and match against the current Compare
  always_comb begin
    count_nxt = wr_count ? wr_data : count + DATA_W'(1);
    fire      = (count_nxt == compare) && (compare != '0);
  end

  // Count/Compare state; a Compare write clears the flag even on a match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      compare   <= '0;
      timer_irq <= 1'b0;
    end else if (TIMER_EN != 0) begin
      count <= count_nxt;
      if (wr_compare) begin
        compare   <= wr_data;
        timer_irq <= 1'b0;
      end else if (fire) begin
        timer_irq <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_param.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception arbitration, optional timer.
// Latency: int_req and rd_data combinational; register updates on the next edge.
// Backpressure: none; an mtc0 in the same cycle as int_req is dropped (instruction flushed).
module cp0_param
  import cp0_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_HWINT = 6,
  parameter int          TIMER_EN  = 1,
  parameter logic [31:0] PRID      = 32'h4255_4141
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W-1:0]    pc_m,
  input  logic                 bd_m,
  input  logic [4:0]           exc_code_m,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 exl_clr,
  output logic                 int_req,
  output logic [DATA_W-1:0]    epc_out,
  output logic                 timer_irq
);

  logic [NUM_HWINT-1:0] im;
  logic                 exl;
  logic                 ie;
  logic                 bd;
  logic [NUM_HWINT-1:0] ip_q;
  logic [4:0]           exc_code;
  logic [DATA_W-1:0]    epc;
  logic [DATA_W-1:0]    count;
  logic [DATA_W-1:0]    compare;

  logic [NUM_HWINT-1:0] ip;
  logic                 irq;
  logic                 exc;
  logic [DATA_W-1:0]    pc_al;
  logic [DATA_W-1:0]    epc_nxt;
  logic                 mtc0_ok;
  logic [DATA_W-1:0]    sr_val;
  logic [DATA_W-1:0]    cause_val;
  logic                 unused_pc_lsb;

  assign unused_pc_lsb = &{1'b0, pc_m[1:0]};

  // live pending vector, arbitration and exception PC
  always_comb begin
    ip                = hw_int;
    ip[NUM_HWINT-1]   = hw_int[NUM_HWINT-1] | timer_irq;
    irq               = ie & ~exl & (|(ip & im));
    exc               = ~exl & (exc_code_m != 5'd0);
    int_req           = irq | exc;
    mtc0_ok           = wr_en & ~int_req;
    pc_al             = {pc_m[DATA_W-1:2], 2'b00};
    epc_nxt           = bd_m ? pc_al - DATA_W'(4) : pc_al;
  end

  // SR/Cause/EPC state; exception entry overrides eret clear and mtc0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip_q     <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip_q <= ip;
      if (int_req) begin
        exl      <= 1'b1;
        bd       <= bd_m;
        exc_code <= irq ? EXC_INT : exc_code_m;
        epc      <= epc_nxt;
      end else begin
        if (exl_clr) exl <= 1'b0;
        if (wr_en && wr_addr == REG_SR) begin
          im  <= wr_data[IM_LSB +: NUM_HWINT];
          exl <= wr_data[SR_EXL];
          ie  <= wr_data[SR_IE];
        end
        if (wr_en && wr_addr == REG_EPC) epc <= wr_data;
      end
    end
  end

  generate
    if (TIMER_EN != 0) begin : g_timer
      cp0_timer #(
        .DATA_W   (DATA_W),
        .TIMER_EN (TIMER_EN)
      ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count   (mtc0_ok && wr_addr == REG_COUNT),
        .wr_compare (mtc0_ok && wr_addr == REG_COMPARE),
        .wr_data    (wr_data),
        .count      (count),
        .compare    (compare),
        .timer_irq  (timer_irq)
      );
    end else begin : g_no_timer
      assign count     = '0;
      assign compare   = '0;
      assign timer_irq = 1'b0;
    end
  endgenerate

  // mfc0 read mux; unmapped numbers read zero
  always_comb begin
    sr_val                         = '0;
    sr_val[IM_LSB +: NUM_HWINT]    = im;
    sr_val[SR_EXL]                 = exl;
    sr_val[SR_IE]                  = ie;
    cause_val                      = '0;
    cause_val[CAUSE_BD]            = bd;
    cause_val[IM_LSB +: NUM_HWINT] = ip_q;
    cause_val[EXC_LSB +: 5]        = exc_code;
    case (rd_addr)
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
      REG_SR:      rd_data = sr_val;
      REG_CAUSE:   rd_data = cause_val;
      REG_EPC:     rd_data = epc;
      REG_PRID:    rd_data = DATA_W'(PRID);
      default:     rd_data = '0;
    endcase
  end

  // EPC view with same-cycle mtc0 bypass
  always_comb begin
    epc_out = (wr_en && wr_addr == REG_EPC) ? wr_data : epc;
  end

endmodule

// File: tb/tb_cp0_param.sv
module tb_cp0_param;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc_out;
  logic        timer_irq;

  int checks;
  int errors;

  cp0_param #(
    .DATA_W    (32),
    .NUM_HWINT (6),
    .TIMER_EN  (1),
    .PRID      (32'h4255_4141)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .hw_int     (hw_int),
    .exl_clr    (exl_clr),
    .int_req    (int_req),
    .epc_out    (epc_out),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // combinational mfc0 read
  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  // one-cycle mtc0
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; pc_m = 0; bd_m = 0;
    exc_code_m = 0; hw_int = 0; exl_clr = 0; rd_addr = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    idle_inputs();
    #5;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b expected 0", int_req); end
    checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc_out: got %h expected 0", epc_out); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_timer_irq: got %b expected 0", timer_irq); end
    tick();
    rd(5'd12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h expected 0", v); end
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected 0", v); end
    rd(5'd9, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", v); end
    rd(5'd11, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_compare: got %h expected 0", v); end
    rd(5'd15, v); checks++; if (v !== 32'h4255_4141) begin errors++; $display("FAIL prid: got %h expected 42554141", v); end
    rd(5'd3, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", v); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_FC01);
    rd(5'd12, v); checks++; if (v !== 32'h0000_3C01) begin errors++; $display("FAIL sr_write_mask: got %h expected 00003c01", v); end
    hw_int = 6'b000100;
    pc_m   = 32'h0000_0400;
    #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL irq_same_cycle: got %b expected 1", int_req); end
    tick();
    hw_int = 6'b0;
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_after_entry: got %b expected 0", int_req); end
    checks++; if (epc_out !== 32'h0000_0400) begin errors++; $display("FAIL irq_epc: got %h expected 00000400", epc_out); end
    rd(5'd12, v); checks++; if (v !== 32'h0000_3C03) begin errors++; $display("FAIL irq_exl: got %h expected 00003c03", v); end
    rd(5'd13, v); checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL irq_cause: got %h expected 00000400", v); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    rd(5'd12, v); checks++; if (v !== 32'h0000_3C01) begin errors++; $display("FAIL eret_clear: got %h expected 00003c01", v); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    exc_code_m = 5'd12;
    bd_m       = 1'b1;
    pc_m       = 32'h0000_3010;
    #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL exc_same_cycle: got %b expected 1", int_req); end
    tick();
    exc_code_m = 0; bd_m = 0;
    #1;
    checks++; if (epc_out !== 32'h0000_300C) begin errors++; $display("FAIL exc_bd_epc: got %h expected 0000300c", epc_out); end
    rd(5'd13, v); checks++; if (v !== 32'h8000_0030) begin errors++; $display("FAIL exc_cause: got %h expected 80000030", v); end
    rd(5'd12, v); checks++; if (v[1] !== 1'b1) begin errors++; $display("FAIL exc_exl: got %b expected 1", v[1]); end
  endtask

  // entered with EXL=1 from the previous scenario
  task automatic test_exl_block();
    hw_int = 6'h3F;
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL exl_blocks_irq: got %b expected 0", int_req); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL irq_after_eret: got %b expected 1", int_req); end
    hw_int = 6'h0;
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", int_req); end
    tick();
  endtask

  task automatic test_timer();
    logic [31:0] v;
    mtc0(5'd9, 32'd100);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    pc_m = 32'h0000_5000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_early_%0d: got %b expected 0", i, timer_irq); end
    end
    tick();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_fire: got %b expected 1", timer_irq); end
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL timer_int_req: got %b expected 1", int_req); end
    tick();
    rd(5'd13, v); checks++; if (v !== 32'h0000_2000) begin errors++; $display("FAIL timer_cause: got %h expected 00002000", v); end
    mtc0(5'd11, 32'd5);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b expected 0", timer_irq); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_flush_wins();
    logic [31:0] v;
    hw_int  = 6'b001000;
    pc_m    = 32'h0000_2000;
    wr_en   = 1'b1;
    wr_addr = 5'd14;
    wr_data = 32'h0000_1234;
    #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL flush_int_req: got %b expected 1", int_req); end
    tick();
    wr_en = 0; hw_int = 0;
    #1;
    checks++; if (epc_out !== 32'h0000_2000) begin errors++; $display("FAIL flush_epc: got %h expected 00002000", epc_out); end
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    mtc0(5'd14, 32'h0000_0ABC);
    rd(5'd14, v); checks++; if (v !== 32'h0000_0ABC) begin errors++; $display("FAIL mtc0_epc: got %h expected 00000abc", v); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] v;
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, v); checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_load: got %h expected ffffffff", v); end
    tick();
    rd(5'd9, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h expected 0", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    exc_code_m = 5'd4;
    pc_m       = 32'h0000_0100;
    tick();
    exc_code_m = 0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL rst_mid_epc: got %h expected 0", epc_out); end
    rd(5'd12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_sr: got %h expected 0", v); end
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_cause: got %h expected 0", v); end
    rd(5'd9, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_count: got %h expected 0", v); end
    rd(5'd11, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_compare: got %h expected 0", v); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  // randomized traffic against an architectural model of CP0
  task automatic test_random();
    logic        m_ie, m_exl, m_bd, m_tirq;
    logic [5:0]  m_im, m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_count, m_cmp;
    logic [5:0]  live_ip;
    logic        m_irq, m_req, wr_cnt, wr_cmp, fire;
    logic [31:0] exp_rd, exp_epc, new_count, pc_al;
    logic [4:0]  addr_tab [8];
    logic [4:0]  exc_tab [4];
    addr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd20};
    exc_tab  = '{5'd4, 5'd5, 5'd10, 5'd12};

    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    m_ie = 0; m_exl = 0; m_bd = 0; m_tirq = 0; m_im = 0; m_ip = 0;
    m_exc = 0; m_epc = 0; m_count = 0; m_cmp = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = addr_tab[$urandom_range(0, 7)];
      case (wr_addr)
        5'd11:   wr_data = m_count + $urandom_range(2, 20);
        5'd12:   wr_data = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0000_3F01 & $urandom);
        default: wr_data = $urandom;
      endcase
      hw_int     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
      exc_code_m = ($urandom_range(0, 9) == 0) ? exc_tab[$urandom_range(0, 3)] : 5'd0;
      bd_m       = 1'($urandom);
      pc_m       = $urandom;
      exl_clr    = !wr_en && ($urandom_range(0, 4) == 0);
      rd_addr    = addr_tab[$urandom_range(0, 7)];
      #1;

      live_ip = hw_int | (m_tirq ? 6'b100000 : 6'b0);
      m_irq   = m_ie && !m_exl && ((live_ip & m_im) != 0);
      m_req   = m_irq || (!m_exl && exc_code_m != 0);
      case (rd_addr)
        5'd9:    exp_rd = m_count;
        5'd11:   exp_rd = m_cmp;
        5'd12:   exp_rd = {18'b0, m_im, 6'b0, m_exl, m_ie};
        5'd13:   exp_rd = {m_bd, 17'b0, m_ip, 1'b0, m_exc, 2'b0};
        5'd14:   exp_rd = m_epc;
        5'd15:   exp_rd = 32'h4255_4141;
        default: exp_rd = 32'h0;
      endcase
      exp_epc = (wr_en && wr_addr == 5'd14) ? wr_data : m_epc;

      checks++; if (int_req !== m_req) begin errors++; $display("FAIL rand_int_req cyc %0d: got %b expected %b", cyc, int_req, m_req); end
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rand_rd_data cyc %0d addr %0d: got %h expected %h", cyc, rd_addr, rd_data, exp_rd); end
      checks++; if (epc_out !== exp_epc) begin errors++; $display("FAIL rand_epc_out cyc %0d: got %h expected %h", cyc, epc_out, exp_epc); end
      checks++; if (timer_irq !== m_tirq) begin errors++; $display("FAIL rand_timer_irq cyc %0d: got %b expected %b", cyc, timer_irq, m_tirq); end

      @(posedge clk);
      // architectural effect of this cycle
      m_ip   = live_ip;
      wr_cnt = wr_en && !m_req && wr_addr == 5'd9;
      wr_cmp = wr_en && !m_req && wr_addr == 5'd11;
      if (m_req) begin
        pc_al = pc_m & 32'hFFFF_FFFC;
        m_exl = 1;
        m_bd  = bd_m;
        m_exc = m_irq ? 5'd0 : exc_code_m;
        m_epc = bd_m ? pc_al - 32'd4 : pc_al;
      end else begin
        if (exl_clr) m_exl = 0;
        if (wr_en && wr_addr == 5'd12) begin
          m_im  = wr_data[13:8];
          m_exl = wr_data[1];
          m_ie  = wr_data[0];
        end
        if (wr_en && wr_addr == 5'd14) m_epc = wr_data;
      end
      new_count = wr_cnt ? wr_data : m_count + 32'd1;
      fire      = (new_count == m_cmp) && (m_cmp != 0);
      if (wr_cmp) begin
        m_tirq = 0;
        m_cmp  = wr_data;
      end else if (fire) begin
        m_tirq = 1;
      end
      m_count = new_count;
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_interrupt();
    test_exception();
    test_exl_block();
    test_timer();
    test_flush_wins();
    test_count_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
